// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DFLT = 0;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin winner select: rotate the eligible mask to start after the
// last grant, priority-encode, then map the offset back to a port index.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  last,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    logic [IDW:0]    start;
    logic [IDW:0]    off;
    logic [IDW:0]    sum;
    logic [NREQ-1:0] rot;

    always_comb begin
        start = (last >= IDW'(NREQ - 1)) ? '0 : {1'b0, last} + 1'b1;
        rot   = NREQ'({eligible, eligible} >> start);
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDW+1)'(i);
        end
        sum = start + off;
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        winner = sum[IDW-1:0];
        any    = |eligible;
    end

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter multiplexing NREQ requester ports onto one memory port,
// with per-port enable masking, a bus watchdog and a grant-id output.
//
// state   | meaning
// IDLE    | waiting for an eligible request; arbitrates every cycle
// BUSY    | master request outstanding for port cur; watchdog running
// RELEASE | one-cycle completion/abort pulse; no arbitration
module arb_rr
    import arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = TIMEOUT_DFLT,
    localparam int IDW    = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_en,
    input  logic [NREQ*AW-1:0] addr_a,
    input  logic [NREQ*DW-1:0] dout_a,
    input  logic [NREQ-1:0]    req_a,
    input  logic [NREQ-1:0]    wr_a,
    output logic [NREQ*DW-1:0] din_a,
    output logic [NREQ-1:0]    rdy_a,
    output logic [NREQ-1:0]    err_a,
    output logic [AW-1:0]      addr_m,
    output logic [DW-1:0]      dout_m,
    output logic               req_m,
    output logic               wr_m,
    input  logic [DW-1:0]      din_m,
    input  logic               rdy_m,
    output logic               busy,
    output logic [IDW-1:0]     grant_id
);

    localparam int TCW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT - 1);

    arb_state_e      state, state_nxt;
    logic [IDW-1:0]  last, last_nxt;
    logic [IDW-1:0]  cur, cur_nxt;
    logic [TCW-1:0]  tcnt, tcnt_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   dout_nxt;
    logic            req_nxt, wr_nxt;
    logic [NREQ-1:0] rdy_nxt, err_nxt;
    logic [DW-1:0]   din_q, din_nxt;
    logic            any;
    logic [IDW-1:0]  winner;
    logic            timeout_hit;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .eligible (req_a & req_en),
        .last     (last),
        .any      (any),
        .winner   (winner)
    );

    assign timeout_hit = (TIMEOUT > 0) && (tcnt == TC_LAST);
    assign din_a       = {NREQ{din_q}};
    assign grant_id    = cur;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cur_nxt   = cur;
        tcnt_nxt  = tcnt;
        addr_nxt  = addr_m;
        dout_nxt  = dout_m;
        req_nxt   = req_m;
        wr_nxt    = wr_m;
        rdy_nxt   = '0;
        err_nxt   = '0;
        din_nxt   = din_q;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = BUSY;
                    cur_nxt   = winner;
                    tcnt_nxt  = '0;
                    addr_nxt  = addr_a[int'(winner)*AW +: AW];
                    dout_nxt  = dout_a[int'(winner)*DW +: DW];
                    wr_nxt    = wr_a[winner];
                    req_nxt   = 1'b1;
                end
            end
            BUSY: begin
                // completion takes priority over a watchdog expiring on the same edge
                if (rdy_m) begin
                    din_nxt      = din_m;
                    rdy_nxt[cur] = 1'b1;
                    req_nxt      = 1'b0;
                    wr_nxt       = 1'b0;
                    last_nxt     = cur;
                    state_nxt    = RELEASE;
                end else if (timeout_hit) begin
                    err_nxt[cur] = 1'b1;
                    req_nxt      = 1'b0;
                    wr_nxt       = 1'b0;
                    last_nxt     = cur;
                    state_nxt    = RELEASE;
                end else if (tcnt != '1) begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last   <= IDW'(NREQ - 1);
            cur    <= '0;
            tcnt   <= '0;
            addr_m <= '0;
            dout_m <= '0;
            req_m  <= 1'b0;
            wr_m   <= 1'b0;
            rdy_a  <= '0;
            err_a  <= '0;
            din_q  <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            cur    <= cur_nxt;
            tcnt   <= tcnt_nxt;
            addr_m <= addr_nxt;
            dout_m <= dout_nxt;
            req_m  <= req_nxt;
            wr_m   <= wr_nxt;
            rdy_a  <= rdy_nxt;
            err_a  <= err_nxt;
            din_q  <= din_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr (NREQ=4, AW=DW=64, TIMEOUT=8).
module tb_arb_rr;

    localparam int NREQ    = 4;
    localparam int AW      = 64;
    localparam int DW      = 64;
    localparam int TIMEOUT = 8;
    localparam int IDW     = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req_en = '0;
    logic [NREQ*AW-1:0] addr_a = '0;
    logic [NREQ*DW-1:0] dout_a = '0;
    logic [NREQ-1:0]    req_a = '0;
    logic [NREQ-1:0]    wr_a = '0;
    logic [NREQ*DW-1:0] din_a;
    logic [NREQ-1:0]    rdy_a;
    logic [NREQ-1:0]    err_a;
    logic [AW-1:0]      addr_m;
    logic [DW-1:0]      dout_m;
    logic               req_m;
    logic               wr_m;
    logic [DW-1:0]      din_m = '0;
    logic               rdy_m = 1'b0;
    logic               busy;
    logic [IDW-1:0]     grant_id;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    arb_rr #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_en   (req_en),
        .addr_a   (addr_a),
        .dout_a   (dout_a),
        .req_a    (req_a),
        .wr_a     (wr_a),
        .din_a    (din_a),
        .rdy_a    (rdy_a),
        .err_a    (err_a),
        .addr_m   (addr_m),
        .dout_m   (dout_m),
        .req_m    (req_m),
        .wr_m     (wr_m),
        .din_m    (din_m),
        .rdy_m    (rdy_m),
        .busy     (busy),
        .grant_id (grant_id)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; waits for req_m and checks grant and idle gap.
    task automatic wait_grant(input string tag, input int exp_id, input int exp_lows);
        int lows;
        lows = 0;
        while (!req_m && lows < 40) begin
            @(negedge clk);
            lows++;
        end
        check({tag, "_req_m"}, req_m, 1);
        check({tag, "_grant_id"}, grant_id, exp_id);
        check({tag, "_gap"}, lows, exp_lows);
    endtask

    // Pulses rdy_m for one edge and checks the completion pulse and read data.
    task automatic complete(input string tag, input int exp_id, input logic [63:0] dm);
        din_m = dm;
        rdy_m = 1'b1;
        @(negedge clk);
        rdy_m = 1'b0;
        din_m = '0;
        check({tag, "_rdy_a"}, rdy_a, 4'b0001 << exp_id);
        check({tag, "_err_a"}, err_a, 0);
        check({tag, "_din_a"}, din_a, {4{dm}});
        check({tag, "_req_m_low"}, req_m, 0);
        check({tag, "_busy_rel"}, busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int ids1 [5];
        int ids2 [6];
        int n;
        ids1 = '{0, 1, 2, 3, 0};
        ids2 = '{0, 1, 3, 0, 1, 3};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_req_m", req_m, 0);
        check("rst_rdy_a", rdy_a, 0);
        check("rst_err_a", err_a, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_addr_m", addr_m, 0);
        check("rst_din_a", din_a, 0);

        // all ports requesting, round robin 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i*AW +: AW] = 64'hA000 + 64'(i);
            dout_a[i*DW +: DW] = 64'hD000 + 64'(i);
        end
        wr_a   = 4'b1010;
        reset  = 1'b1;
        req_en = 4'hF;
        req_a  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("rr%0d", i), ids1[i], (i == 0) ? 1 : 2);
            check($sformatf("rr%0d_addr_m", i), addr_m, 64'hA000 + 64'(ids1[i]));
            check($sformatf("rr%0d_dout_m", i), dout_m, 64'hD000 + 64'(ids1[i]));
            check($sformatf("rr%0d_wr_m", i), wr_m, (ids1[i] % 2 == 1) ? 1 : 0);
            complete($sformatf("rr%0d", i), ids1[i], 64'h100 + 64'(i));
        end
        req_a = '0;

        // rdy_m while idle is ignored
        @(negedge clk);
        check("idle_busy", busy, 0);
        rdy_m = 1'b1;
        din_m = 64'hBAD;
        @(negedge clk);
        rdy_m = 1'b0;
        din_m = '0;
        check("idle_rdy_ign", rdy_a, 0);
        check("idle_din_keep", din_a, {4{64'h104}});
        check("idle_req_m", req_m, 0);

        // port 2 read; dropping req_a mid-BUSY does not abort
        addr_a[2*AW +: AW] = 64'hDEAD_0000;
        wr_a  = 4'b0000;
        req_a = 4'b0100;
        wait_grant("p2", 2, 1);
        check("p2_addr_m", addr_m, 64'hDEAD_0000);
        check("p2_wr_m", wr_m, 0);
        req_a = '0;
        @(negedge clk);
        check("p2_hold_req_m", req_m, 1);
        check("p2_hold_addr_m", addr_m, 64'hDEAD_0000);
        complete("p2", 2, 64'h1234);

        // watchdog abort on port 1
        @(negedge clk);
        req_a = 4'b0010;
        wait_grant("to", 1, 1);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (err_a != 0) break;
            n++;
        end
        check("to_busy_cycles", n, 8);
        check("to_err_a", err_a, 4'b0010);
        check("to_rdy_a", rdy_a, 0);
        check("to_req_m", req_m, 0);
        check("to_din_keep", din_a, {4{64'h1234}});
        req_a = '0;
        @(negedge clk);
        check("to_err_clear", err_a, 0);
        check("to_busy_clear", busy, 0);
        req_a = 4'b1111;
        wait_grant("to_next", 2, 1);
        complete("to_next", 2, 64'h55);
        req_a = '0;

        // rdy_m on the same edge the watchdog expires
        @(negedge clk);
        req_a = 4'b0001;
        wait_grant("tie", 0, 1);
        repeat (7) @(negedge clk);
        check("tie_pre_req_m", req_m, 1);
        complete("tie", 0, 64'hABCD);
        req_a = '0;

        // async reset mid-BUSY
        @(negedge clk);
        req_a = 4'b0100;
        wait_grant("ar", 2, 1);
        check("ar_addr_m", addr_m, 64'hDEAD_0000);
        #2;
        reset = 1'b0;
        #1;
        check("ar_req_m", req_m, 0);
        check("ar_rdy_a", rdy_a, 0);
        check("ar_err_a", err_a, 0);
        check("ar_busy", busy, 0);
        check("ar_addr_m0", addr_m, 0);
        check("ar_grant_id", grant_id, 0);
        @(negedge clk);
        req_en = 4'b1011;
        req_a  = 4'b1111;
        @(negedge clk);
        check("ar_hold_req_m", req_m, 0);
        reset = 1'b1;

        // masked port 2 never granted
        for (int i = 0; i < 6; i++) begin
            wait_grant($sformatf("en%0d", i), ids2[i], (i == 0) ? 1 : 2);
            complete($sformatf("en%0d", i), ids2[i], 64'h200 + 64'(i));
        end
        req_a = '0;
        @(negedge clk);
        @(negedge clk);
        check("end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arb_rr.md
Name: arb_rr

Overview:
- Parametrised round-robin arbiter; next generation of the 4-port memory arbiter.
- Multiplexes NREQ requester ports onto one master memory port. Width, port count and bus-timeout are parameters.
- Adds per-port enable masking, a bus watchdog with per-port error pulse, and a grant-id output.
- Sits between core/DMA request ports and the single memory controller port.

Parameters:
- NREQ, 4, number of requester ports (2..16)
- AW, 64, address width per port
- DW, 64, data width per port
- TIMEOUT, 0, max BUSY cycles waiting for rdy_m before abort; 0 disables the watchdog
- IDW, $clog2(NREQ), width of grant_id (derived, not overridable)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_en  in  NREQ  per-port arbitration enable; 0 masks the port
- addr_a  in  NREQ*AW  flat requester addresses, port i at [i*AW +: AW]
- dout_a  in  NREQ*DW  flat requester write data
- req_a  in  NREQ  request, held high until rdy_a/err_a of that port
- wr_a  in  NREQ  1 = write, 0 = read
- din_a  out  NREQ*DW  read data, registered copy broadcast to every slice
- rdy_a  out  NREQ  one-cycle completion pulse, at most one bit set
- err_a  out  NREQ  one-cycle timeout-abort pulse, at most one bit set
- addr_m  out  AW  master address
- dout_m  out  DW  master write data
- req_m  out  1  master request
- wr_m  out  1  master write strobe
- din_m  in  DW  master read data, valid with rdy_m
- rdy_m  in  1  master completion
- busy  out  1  high in BUSY and RELEASE states
- grant_id  out  IDW  index of current or last granted port

Behaviour:
- All outputs and state are registered.
- Reset (reset=0, async): state IDLE, last=NREQ-1, cur=0, tcnt=0. All outputs 0. Port 0 wins the first arbitration.
- Reset asserted mid-transaction: immediate return to IDLE with req_m=0. No rdy_a or err_a is issued.
- States: IDLE, BUSY, RELEASE.
- IDLE, eligible = req_a & req_en:
  - If eligible is nonzero, winner = first set bit scanning last+1, last+2, ... modulo NREQ.
  - Next edge: cur=winner, grant_id=winner, state=BUSY.
  - addr_m, dout_m and wr_m are latched from the winner's slice and held constant for the whole of BUSY; req_m=1.
  - Otherwise stay in IDLE.
- Latency: req_a sampled high in cycle T gives req_m=1 in cycle T+1.
- BUSY, rdy_m=1 at an edge:
  - din_a (all slices) <= din_m; rdy_a[cur]=1; req_m=0; wr_m=0; last=cur; state=RELEASE.
  - rdy_a and din_a are therefore valid together, one cycle after rdy_m.
- BUSY, TIMEOUT>0 and tcnt==TIMEOUT-1 with rdy_m=0:
  - err_a[cur]=1; req_m=0; wr_m=0; last=cur; state=RELEASE.
  - din_a is unchanged.
- rdy_m and timeout in the same cycle: rdy_m wins, no err_a.
- tcnt counts BUSY cycles, clears on entry to BUSY, saturates. Width is $clog2(TIMEOUT+1), minimum 1.
- RELEASE: lasts exactly one cycle.
  - rdy_a/err_a clear at the next edge; state=IDLE.
  - No arbitration in RELEASE, so the minimum gap between grants is 2 cycles (req_m low for 2 cycles).
- rdy_m while in IDLE or RELEASE is ignored.
- req_a[cur] dropping during BUSY does not abort the transaction.
- req_en is sampled only in IDLE; clearing it during BUSY does not abort.
- Fairness: a port requesting continuously waits at most NREQ-1 grants.
- grant_id holds its value outside BUSY.

Decomposition:
- Package arb_pkg holds:
  - the state enum (IDLE/BUSY/RELEASE, 2 bits)
  - a clog2 helper function
  - a localparam for the default TIMEOUT
- One sub-module, rr_pick: combinational, parameter NREQ.
  - Inputs: eligible[NREQ], last[IDW].
  - Outputs: any, winner[IDW].
  - Implemented by double-width rotate plus priority encode.
- arb_rr instantiates rr_pick once and owns all sequential logic.

Test Plan (NREQ=4, AW=DW=64):
- Reset release, req_a=4'b1111, rdy_m one cycle after req_m rises each time, req_en=4'hF -> grant_id sequence 0,1,2,3,0; rdy_a pulses 0001,0010,0100,1000; req_m low exactly 2 cycles between grants.
- Port 2 only: req_a=4'b0100, addr_a slice2=64'hDEAD_0000, wr_a[2]=0, rdy_m with din_m=64'h1234 -> addr_m=64'hDEAD_0000 from T+1; rdy_a=4'b0100; all din_a slices =64'h1234 in the same cycle.
- TIMEOUT=8, port 1 requests, rdy_m held 0 -> err_a=4'b0010 after 8 BUSY cycles; rdy_a stays 0; next grant scans from port 2.
- rdy_m raised in the same cycle the timeout expires (TIMEOUT=8) -> rdy_a[cur]=1 and err_a=0.
- req_en=4'b1011, req_a=4'b1111 continuously -> grant order 0,1,3,0,1,3; port 2 never granted.
- reset driven low mid-BUSY with no clock edge -> req_m, rdy_a, busy and addr_m go 0 asynchronously; after release, the first grant goes to the lowest eligible port.
